// File: rtl/nn_pkg.sv
// Shared fixed-point constants and FSM state type for the sequenced neural-network layer.
package nn_pkg;
  localparam int DATA_W    = 20;
  localparam int FRAC_BITS = 12;
  localparam int ACC_W     = 26;
  localparam int PROD_W    = 2 * DATA_W;

  localparam logic signed [DATA_W-1:0] SAT_MAX = 20'sh7FFFF;
  localparam logic signed [DATA_W-1:0] SAT_MIN = 20'sh80000;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    DRAIN = 3'd2,
    OUT   = 3'd3,
    FIN   = 3'd4
  } state_t;
endpackage

// File: rtl/nn_mac_sat.sv
// Combinational multiply/shift/accumulate step with accumulator clamping,
// followed by 20-bit saturation and ReLU of the updated accumulator.
module nn_mac_sat
  import nn_pkg::*;
#(
  parameter int FRAC_W = FRAC_BITS
) (
  input  logic signed [ACC_W-1:0]  acc,
  input  logic signed [DATA_W-1:0] x,
  input  logic signed [DATA_W-1:0] w,
  input  logic                     load_bias,
  output logic signed [ACC_W-1:0]  acc_nxt,
  output logic signed [DATA_W-1:0] act
);
  localparam int SUM_W = PROD_W - FRAC_W + 1;
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic signed [PROD_W-1:0] prod_s;
  logic signed [PROD_W-1:0] term_s;
  logic signed [SUM_W-1:0]  sum_s;
  logic signed [DATA_W-1:0] sat_s;

  // Accumulate in a wide sum, then clamp so the accumulator never wraps.
  always_comb begin
    prod_s = PROD_W'(x) * PROD_W'(w);
    term_s = prod_s >>> FRAC_W;
    sum_s  = SUM_W'(acc) + SUM_W'(term_s);
    if (load_bias) begin
      acc_nxt = ACC_W'(w);
    end else if (sum_s > SUM_W'(ACC_MAX)) begin
      acc_nxt = ACC_MAX;
    end else if (sum_s < SUM_W'(ACC_MIN)) begin
      acc_nxt = ACC_MIN;
    end else begin
      acc_nxt = ACC_W'(sum_s);
    end
  end

  // Saturate to the 20-bit data range, then apply ReLU.
  always_comb begin
    if (acc_nxt > ACC_W'(SAT_MAX)) begin
      sat_s = SAT_MAX;
    end else if (acc_nxt < ACC_W'(SAT_MIN)) begin
      sat_s = SAT_MIN;
    end else begin
      sat_s = DATA_W'(acc_nxt);
    end
    if (sat_s[DATA_W-1]) begin
      act = '0;
    end else begin
      act = sat_s;
    end
  end
endmodule

// File: rtl/hidden_layer_seq.sv
// Hidden layer evaluator: sequences N_NEURON neurons through one shared MAC,
// fetching bias and weights from an external 1-cycle-latency memory.
module hidden_layer_seq
  import nn_pkg::DATA_W, nn_pkg::ACC_W, nn_pkg::state_t,
         nn_pkg::IDLE, nn_pkg::FETCH, nn_pkg::DRAIN, nn_pkg::OUT, nn_pkg::FIN;
#(
  parameter int N_NEURON  = 4,
  parameter int N_IN      = 2,
  parameter int FRAC_BITS = nn_pkg::FRAC_BITS,
  localparam int AW = (N_NEURON * (N_IN + 1) > 1) ? $clog2(N_NEURON * (N_IN + 1)) : 1,
  localparam int IW = (N_NEURON > 1) ? $clog2(N_NEURON) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic signed [DATA_W-1:0] C_out,
  input  logic signed [DATA_W-1:0] E_out,
  output logic [AW-1:0]            w_addr,
  input  logic signed [DATA_W-1:0] w_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [IW-1:0]            out_idx,
  output logic signed [DATA_W-1:0] N_out,
  output logic                     busy,
  output logic                     done
);
  localparam int KW = $clog2(N_IN + 2);

  state_t                   state_r, state_nxt_s;
  logic signed [DATA_W-1:0] x0_r, x1_r, x_sel_s, act_s, n_out_r;
  logic signed [ACC_W-1:0]  acc_r, acc_nxt_s;
  logic [IW-1:0]            j_r, j_nxt_s;
  logic [KW-1:0]            k_r, k_nxt_s, elem_s;
  logic [AW-1:0]            w_addr_r, addr_nxt_s;
  logic                     consume_s, out_valid_r, busy_r, done_r;

  function automatic logic [AW-1:0] addr_of(input logic [IW-1:0] j, input logic [KW-1:0] k);
    return AW'(32'(j) * 32'(N_IN + 1) + 32'(k));
  endfunction

  // Next-state, neuron/element indexing and next memory address.
  always_comb begin
    state_nxt_s = state_r;
    j_nxt_s     = j_r;
    k_nxt_s     = k_r;
    addr_nxt_s  = w_addr_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s = FETCH;
          j_nxt_s     = '0;
          k_nxt_s     = '0;
          addr_nxt_s  = '0;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      FETCH: begin
        k_nxt_s = k_r + KW'(1);
        if (k_r == KW'(N_IN)) begin
          state_nxt_s = DRAIN;
        end else begin
          state_nxt_s = FETCH;
          addr_nxt_s  = addr_of(j_r, k_r + KW'(1));
        end
      end
      DRAIN: state_nxt_s = OUT;
      OUT: begin
        if (!out_ready) begin
          state_nxt_s = OUT;
        end else if (j_r == IW'(N_NEURON - 1)) begin
          state_nxt_s = FIN;
        end else begin
          state_nxt_s = FETCH;
          j_nxt_s     = j_r + IW'(1);
          k_nxt_s     = '0;
          addr_nxt_s  = addr_of(j_r + IW'(1), KW'(0));
        end
      end
      FIN:     state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Data returned for the previous address: element k-1 (0 = bias).
  always_comb begin
    elem_s = k_r - KW'(1);
    if ((state_r == FETCH && k_r != KW'(0)) || state_r == DRAIN) begin
      consume_s = 1'b1;
    end else begin
      consume_s = 1'b0;
    end
    if (elem_s == KW'(1)) begin
      x_sel_s = x0_r;
    end else begin
      x_sel_s = x1_r;
    end
  end

  nn_mac_sat #(.FRAC_W(FRAC_BITS)) u_mac (
    .acc       (acc_r),
    .x         (x_sel_s),
    .w         (w_data),
    .load_bias (elem_s == KW'(0)),
    .acc_nxt   (acc_nxt_s),
    .act       (act_s)
  );

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      x0_r        <= '0;
      x1_r        <= '0;
      j_r         <= '0;
      k_r         <= '0;
      acc_r       <= '0;
      w_addr_r    <= '0;
      n_out_r     <= '0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      j_r         <= j_nxt_s;
      k_r         <= k_nxt_s;
      w_addr_r    <= addr_nxt_s;
      out_valid_r <= (state_nxt_s == OUT);
      busy_r      <= (state_nxt_s != IDLE);
      done_r      <= (state_nxt_s == FIN);
      if (state_r == IDLE && start) begin
        x0_r <= C_out;
        x1_r <= E_out;
      end
      if (consume_s) begin
        acc_r <= acc_nxt_s;
      end
      if (state_r == DRAIN) begin
        n_out_r <= act_s;
      end
    end
  end

  assign w_addr    = w_addr_r;
  assign out_valid = out_valid_r;
  assign out_idx   = j_r;
  assign N_out     = n_out_r;
  assign busy      = busy_r;
  assign done      = done_r;
endmodule

// File: tb/tb_hidden_layer_seq.sv
// Directed self-checking bench for hidden_layer_seq with a 1-cycle-latency
// weight memory model and hand-computed expected neuron outputs.
module tb_hidden_layer_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic out_ready = 1'b0;
  logic signed [19:0] c_out = 20'sd0;
  logic signed [19:0] e_out = 20'sd0;
  logic signed [19:0] w_data = 20'sd0;
  logic signed [19:0] n_out;
  logic [3:0] w_addr;
  logic [1:0] out_idx;
  logic out_valid, busy, done;

  logic signed [19:0] mem [12];
  logic signed [19:0] got_val [8];
  logic [1:0]         got_idx [8];
  int got_n = 0;
  int cyc = 0;
  int errors = 0;
  int checks = 0;

  hidden_layer_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .C_out(c_out), .E_out(e_out),
    .w_addr(w_addr), .w_data(w_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_idx(out_idx), .N_out(n_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    w_data <= mem[w_addr];
  end

  task automatic fill(input logic signed [19:0] b, input logic signed [19:0] w);
    for (int i = 0; i < 12; i++) mem[i] = ((i % 3) == 0) ? b : w;
  endtask

  task automatic run_layer(input logic signed [19:0] a, input logic signed [19:0] b,
                           output int lat, output int ndone);
    int s0;
    got_n = 0; lat = -1; ndone = 0;
    @(negedge clk);
    c_out = a; e_out = b; start = 1'b1; out_ready = 1'b1; s0 = cyc;
    for (int t = 1; t <= 30; t++) begin
      @(negedge clk);
      start = 1'b0;
      if (out_valid && got_n < 8) begin
        got_idx[got_n] = out_idx; got_val[got_n] = n_out; got_n++;
      end
      if (done) begin
        ndone++;
        if (lat < 0) lat = cyc - s0;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    checks += 6;
    if (busy !== 1'b0)      begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
    if (done !== 1'b0)      begin errors++; $display("FAIL rst_done got=%b exp=0", done); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", out_valid); end
    if (n_out !== 20'sd0)   begin errors++; $display("FAIL rst_nout got=%h exp=0", n_out); end
    if (out_idx !== 2'd0)   begin errors++; $display("FAIL rst_idx got=%0d exp=0", out_idx); end
    if (w_addr !== 4'd0)    begin errors++; $display("FAIL rst_addr got=%0d exp=0", w_addr); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic(input string tag);
    int lat, nd;
    fill(20'sh00000, 20'sh01000);
    run_layer(20'sh04200, 20'sh04100, lat, nd);
    checks += 4;
    if (got_n !== 4) begin errors++; $display("FAIL %s_count got=%0d exp=4", tag, got_n); end
    if (lat !== 21)  begin errors++; $display("FAIL %s_latency got=%0d exp=21", tag, lat); end
    if (nd !== 1)    begin errors++; $display("FAIL %s_done_pulses got=%0d exp=1", tag, nd); end
    if (busy !== 1'b0) begin errors++; $display("FAIL %s_idle got=%b exp=0", tag, busy); end
    for (int i = 0; i < 4 && i < got_n; i++) begin
      checks += 2;
      if (got_idx[i] !== 2'(i)) begin errors++; $display("FAIL %s_idx%0d got=%0d exp=%0d", tag, i, got_idx[i], i); end
      if (got_val[i] !== 20'sh08300) begin errors++; $display("FAIL %s_val%0d got=%h exp=08300", tag, i, got_val[i]); end
    end
  endtask

  task automatic test_relu;
    int lat, nd;
    logic signed [19:0] exp_v [4];
    fill(20'sh00000, 20'sh01000);
    mem[3] = 20'shFF000; mem[4] = 20'shFF000; mem[5] = 20'shFF000;
    mem[9] = 20'sh10000; mem[10] = 20'shFFFFF; mem[11] = 20'sh00000;
    exp_v[0] = 20'sh08300; exp_v[1] = 20'sh00000; exp_v[2] = 20'sh08300; exp_v[3] = 20'sh0FFFB;
    run_layer(20'sh04200, 20'sh04100, lat, nd);
    checks += 1;
    if (got_n !== 4) begin errors++; $display("FAIL relu_count got=%0d exp=4", got_n); end
    for (int i = 0; i < 4 && i < got_n; i++) begin
      checks += 1;
      if (got_val[i] !== exp_v[i]) begin errors++; $display("FAIL relu_val%0d got=%h exp=%h", i, got_val[i], exp_v[i]); end
    end
  endtask

  task automatic test_sat;
    int lat, nd;
    fill(20'sh00000, 20'sh7FFFF);
    run_layer(20'sh7FFFF, 20'sh7FFFF, lat, nd);
    checks += 1;
    if (got_n !== 4) begin errors++; $display("FAIL sat_count got=%0d exp=4", got_n); end
    for (int i = 0; i < 4 && i < got_n; i++) begin
      checks += 1;
      if (got_val[i] !== 20'sh7FFFF) begin errors++; $display("FAIL sat_val%0d got=%h exp=7ffff", i, got_val[i]); end
    end
  endtask

  task automatic test_stall;
    int s0, lat, nd, held;
    logic signed [19:0] hv;
    fill(20'sh00000, 20'sh01000);
    got_n = 0; lat = -1; nd = 0; held = 0; hv = 20'sd0;
    @(negedge clk);
    c_out = 20'sh04200; e_out = 20'sh04100; start = 1'b1; out_ready = 1'b1; s0 = cyc;
    @(negedge clk);
    start = 1'b0; c_out = 20'sd0; e_out = 20'sd0;
    for (int t = 2; t <= 40; t++) begin
      if (out_valid && out_idx == 2'd2 && held < 3) begin
        if (held == 0) begin
          hv = n_out; start = 1'b1;
        end else begin
          start = 1'b0;
          checks += 3;
          if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid%0d got=%b exp=1", held, out_valid); end
          if (out_idx !== 2'd2)   begin errors++; $display("FAIL stall_idx%0d got=%0d exp=2", held, out_idx); end
          if (n_out !== hv)       begin errors++; $display("FAIL stall_nout%0d got=%h exp=%h", held, n_out, hv); end
        end
        out_ready = 1'b0; held++;
      end else begin
        start = 1'b0; out_ready = 1'b1;
        if (out_valid && got_n < 8) begin
          got_idx[got_n] = out_idx; got_val[got_n] = n_out; got_n++;
        end
      end
      if (done) begin
        nd++;
        if (lat < 0) lat = cyc - s0;
      end
      @(negedge clk);
    end
    checks += 5;
    if (held !== 3)  begin errors++; $display("FAIL stall_seen got=%0d exp=3", held); end
    if (got_n !== 4) begin errors++; $display("FAIL stall_count got=%0d exp=4", got_n); end
    if (lat !== 24)  begin errors++; $display("FAIL stall_latency got=%0d exp=24", lat); end
    if (nd !== 1)    begin errors++; $display("FAIL stall_done_pulses got=%0d exp=1", nd); end
    if (busy !== 1'b0) begin errors++; $display("FAIL stall_restart got=%b exp=0", busy); end
    for (int i = 0; i < 4 && i < got_n; i++) begin
      checks += 2;
      if (got_idx[i] !== 2'(i)) begin errors++; $display("FAIL stall_idx_out%0d got=%0d exp=%0d", i, got_idx[i], i); end
      if (got_val[i] !== 20'sh08300) begin errors++; $display("FAIL stall_val%0d got=%h exp=08300", i, got_val[i]); end
    end
  endtask

  task automatic test_reset_mid;
    int t, nd;
    bit found;
    fill(20'sh00000, 20'sh01000);
    nd = 0; found = 1'b0;
    @(negedge clk);
    c_out = 20'sh04200; e_out = 20'sh04100; start = 1'b1; out_ready = 1'b1;
    for (t = 0; t < 40 && !found; t++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) nd++;
      if (busy && w_addr == 4'd6) found = 1'b1;
    end
    checks += 1;
    if (!found) begin errors++; $display("FAIL mid_reach_neuron2 got=0 exp=1"); end
    #2 rst_n = 1'b0;
    #1;
    checks += 7;
    if (nd !== 0)           begin errors++; $display("FAIL mid_early_done got=%0d exp=0", nd); end
    if (busy !== 1'b0)      begin errors++; $display("FAIL mid_busy got=%b exp=0", busy); end
    if (done !== 1'b0)      begin errors++; $display("FAIL mid_done got=%b exp=0", done); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got=%b exp=0", out_valid); end
    if (n_out !== 20'sd0)   begin errors++; $display("FAIL mid_nout got=%h exp=0", n_out); end
    if (out_idx !== 2'd0)   begin errors++; $display("FAIL mid_idx got=%0d exp=0", out_idx); end
    if (w_addr !== 4'd0)    begin errors++; $display("FAIL mid_addr got=%0d exp=0", w_addr); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    test_basic("post_rst");
  endtask

  initial begin
    test_reset();
    test_basic("basic");
    test_relu();
    test_sat();
    test_stall();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/hidden_layer_seq.md
HIDDEN_LAYER_SEQ -- requirements
Module: hidden_layer_seq

Interface
REQ-001 The block SHALL have parameter N_NEURON, default 4, giving the number of hidden neurons sequenced through one shared MAC.
REQ-002 The block SHALL have parameter N_IN, default 2, giving the inputs per neuron (C_out, E_out).
REQ-003 The block SHALL have parameter FRAC_BITS, default 12, giving the fixed-point fraction bits of every 20-bit signed datum (Q8.12).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: the reset, asynchronous and active-low.
REQ-006 The block SHALL have port start, input, 1 bit: a request to evaluate the layer, sampled only in IDLE.
REQ-007 The block SHALL have port C_out, input, signed 20 bits: input x0, captured on start acceptance.
REQ-008 The block SHALL have port E_out, input, signed 20 bits: input x1, captured on start acceptance.
REQ-009 The block SHALL have port w_addr, output, clog2(N_NEURON*(N_IN+1)) bits: the weight/bias memory address.
REQ-010 The block SHALL have port w_data, input, signed 20 bits: the memory read data, valid exactly 1 cycle after w_addr.
REQ-011 The block SHALL have port out_valid, output, 1 bit: out_idx and N_out hold a finished neuron result.
REQ-012 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result while out_valid=1.
REQ-013 The block SHALL have port out_idx, output, clog2(N_NEURON) bits: the index of the neuron being output.
REQ-014 The block SHALL have port N_out, output, signed 20 bits: the activated neuron result.
REQ-015 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-016 The block SHALL have port done, output, 1 bit: a single-cycle pulse after the last neuron is accepted.

Function
REQ-017 The block SHALL implement the states IDLE, FETCH, DRAIN, OUT and FIN.
REQ-018 In IDLE with start=1, the block SHALL latch C_out/E_out into x0/x1, set neuron index j=0 and element index k=0, and go to FETCH.
REQ-019 In FETCH, the block SHALL drive w_addr=j*(N_IN+1)+k, where k=0 is the bias and k=1..N_IN are the weights for x(k-1), and SHALL increment k each cycle for N_IN+1 cycles, then go to DRAIN.
REQ-020 Each cycle after an address issue, the block SHALL consume w_data as follows: k=0 loads acc=sign-extended bias; k>=1 adds acc+=(x(k-1)*w_data)>>>FRAC_BITS, using a 40-bit product, arithmetic shift and truncation.
REQ-021 acc SHALL be 26 bits signed, and intermediate accumulation SHALL NOT wrap.
REQ-022 DRAIN SHALL consume the final w_data, then go to OUT; per-neuron latency from first w_addr to out_valid SHALL be N_IN+2 cycles.
REQ-023 In OUT, the block SHALL output N_out=ReLU(sat20(acc)), where sat20 clamps to [0x80000, 0x7FFFF], and ReLU maps negative values to 0.
REQ-024 In OUT, out_valid SHALL be 1 and N_out/out_idx SHALL be held stable until out_ready=1.
REQ-025 On OUT with out_ready=1: if j<N_NEURON-1, the block SHALL set j+=1, k=0 and go to FETCH (no idle cycle); otherwise it SHALL go to FIN.
REQ-026 In FIN, done SHALL be 1 for one cycle, then the block SHALL go to IDLE.
REQ-027 start SHALL be ignored while busy=1, and x0/x1 SHALL NOT change outside start acceptance.
REQ-028 out_ready=1 while out_valid=0 SHALL have no effect.
REQ-029 When out_ready is held high, a full layer SHALL take exactly N_NEURON*(N_IN+3)+1 cycles from start acceptance to done.

Reset
REQ-030 While rst_n=0, the block SHALL be in IDLE with busy=0, done=0, out_valid=0, N_out=0, out_idx=0, w_addr=0, acc=0, x0=x1=0 and j=k=0.
REQ-031 Reset asserted mid-layer SHALL abort immediately, no partial done SHALL be produced, and the first post-reset start SHALL begin cleanly at neuron 0.

Structure
REQ-032 The shared package nn_pkg SHALL hold DATA_W=20, FRAC_BITS=12, ACC_W=26, the sat20 bounds and the state enum.
REQ-033 The multiply/shift/accumulate/saturate datapath SHALL be the sub-module nn_mac_sat; the FSM and addressing SHALL remain in hidden_layer_seq.

Verification
REQ-034 C_out=0x04200 and E_out=0x04100, with every neuron using bias=0 and w=0x01000, SHALL give 4 outputs of N_out=0x08300, out_idx=0..3, and done at cycle 21.
REQ-035 Neuron 1 with bias=0xFF000 (-1.0) and weights 0xFF000 SHALL give N_out=0 from ReLU; all other neurons SHALL be unaffected.
REQ-036 Weights 0x7FFFF with C_out=E_out=0x7FFFF SHALL give N_out=0x7FFFF from saturation, with no wrap.
REQ-037 out_ready held low for 3 cycles at neuron 2 SHALL keep out_valid/N_out/out_idx stable, and a start pulse during the stall SHALL be ignored.
REQ-038 rst_n asserted during FETCH of neuron 2 SHALL force all outputs to their reset values asynchronously, and a subsequent start SHALL reproduce REQ-034 exactly.
